// File: rtl/cache_arbiter_if.sv
// Requester/cache bundle for cache_arbiter: two valid/ready request ports,
// tagged read return and the registered mod_Cache control lines.
interface cache_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          r0_req;
    logic          r0_we;
    logic          r0_lock;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;

    logic          r1_req;
    logic          r1_we;
    logic          r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;

    logic [DW-1:0] rdata;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_dataIn;
    logic          cache_WE;
    logic [DW-1:0] cache_dataOut;

    // Arbiter side
    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  cache_dataOut,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        output rdata, cache_addr, cache_dataIn, cache_WE
    );

    // Requester / cache side
    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output cache_dataOut,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        input  rdata, cache_addr, cache_dataIn, cache_WE
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter with optional lock in front of single-port mod_Cache;
// registers cache controls and routes read data back to the issuing requester.
module cache_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_OWN0 = 2'd1,
        LOCK_OWN1 = 2'd2
    } lock_e;

    lock_e           lock_q, lock_d;
    logic            ptr_q, ptr_d;
    logic [AW-1:0]   cache_addr_q, cache_addr_d;
    logic [DW-1:0]   cache_din_q, cache_din_d;
    logic            cache_we_q, cache_we_d;
    logic [RD_LAT:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT:0] rd_id_q, rd_id_d;

    logic gnt0, gnt1;
    logic issue_rd, issue_id;

    // Grants are withheld during reset so no requester sees a phantom transfer.
    always_comb begin
        gnt0 = bus.r0_req && !rst && (lock_q != LOCK_OWN1) &&
               !((lock_q == LOCK_NONE) && bus.r1_req && ptr_q);
        gnt1 = bus.r1_req && !rst && (lock_q != LOCK_OWN0) &&
               !((lock_q == LOCK_NONE) && bus.r0_req && !ptr_q);
    end

    always_comb begin
        lock_d       = lock_q;
        ptr_d        = ptr_q;
        cache_addr_d = cache_addr_q;
        cache_din_d  = cache_din_q;
        cache_we_d   = 1'b0;
        issue_rd     = 1'b0;
        issue_id     = 1'b0;
        if (gnt0) begin
            ptr_d        = 1'b1;
            lock_d       = bus.r0_lock ? LOCK_OWN0 : LOCK_NONE;
            cache_addr_d = bus.r0_addr;
            cache_din_d  = bus.r0_wdata;
            cache_we_d   = bus.r0_we;
            issue_rd     = !bus.r0_we;
            issue_id     = 1'b0;
        end else if (gnt1) begin
            ptr_d        = 1'b0;
            lock_d       = bus.r1_lock ? LOCK_OWN1 : LOCK_NONE;
            cache_addr_d = bus.r1_addr;
            cache_din_d  = bus.r1_wdata;
            cache_we_d   = bus.r1_we;
            issue_rd     = !bus.r1_we;
            issue_id     = 1'b1;
        end
        // Stage k holds a read issued k+1 cycles ago; the last stage lines up with cache_dataOut.
        rd_vld_d = {rd_vld_q[RD_LAT-1:0], issue_rd};
        rd_id_d  = {rd_id_q[RD_LAT-1:0], issue_id};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= LOCK_NONE;
            ptr_q        <= 1'b0;
            cache_addr_q <= '0;
            cache_din_q  <= '0;
            cache_we_q   <= 1'b0;
            rd_vld_q     <= '0;
            rd_id_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            ptr_q        <= ptr_d;
            cache_addr_q <= cache_addr_d;
            cache_din_q  <= cache_din_d;
            cache_we_q   <= cache_we_d;
            rd_vld_q     <= rd_vld_d;
            rd_id_q      <= rd_id_d;
        end
    end

    assign bus.r0_gnt       = gnt0;
    assign bus.r1_gnt       = gnt1;
    assign bus.r0_rvalid    = rd_vld_q[RD_LAT] && !rd_id_q[RD_LAT];
    assign bus.r1_rvalid    = rd_vld_q[RD_LAT] &&  rd_id_q[RD_LAT];
    assign bus.rdata        = bus.cache_dataOut;
    assign bus.cache_addr   = cache_addr_q;
    assign bus.cache_dataIn = cache_din_q;
    assign bus.cache_WE     = cache_we_q;
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port mod_Cache (16-bit data, 16-bit address, synchronous write on clk).
- Requester 0 is the CPU port; requester 1 is the neuron-update engine.
- Each requester uses a valid/ready handshake. The block registers the cache control signals and tags returning read data back to the issuing requester.
- An optional lock gives one requester exclusive, back-to-back access for read-modify-write.

Parameters:
AW, 16, address width (matches mod_Cache addr)
DW, 16, data width (matches mod_Cache dataIn/dataOut)
RD_LAT, 1, cycles from cache_addr update until cache_dataOut is valid (range 1..4)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 access request; addr/we/wdata/lock stable while high
r0_we  in  1  1=write, 0=read
r0_lock  in  1  keep ownership after this transfer
r0_addr  in  AW  address
r0_wdata  in  DW  write data
r0_gnt  out  1  combinational ready; transfer occurs at the edge where r0_req&&r0_gnt
r0_rvalid  out  1  rdata holds requester 0 read result this cycle
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid  same as r0_*, requester 1
rdata  out  DW  read data, passthrough of cache_dataOut
cache_addr  out  AW  registered address to mod_Cache
cache_dataIn  out  DW  registered write data to mod_Cache
cache_WE  out  1  registered write enable to mod_Cache
cache_dataOut  in  DW  read data from mod_Cache

Behaviour:
- Reset (async, immediate):
  - cache_addr=0, cache_dataIn=0, cache_WE=0.
  - rvalid pipeline cleared, so r0_rvalid=r1_rvalid=0.
  - Priority pointer=0 (requester 0 favoured). Lock owner=NONE.
  - Reset mid-lock or mid-read drops the lock and all pending rvalids. No rvalid is ever emitted for a pre-reset transfer.
- Lock states: NONE, OWN0, OWN1.
  - In OWNi, gnt of the other requester is forced 0.
  - gnt_i = req_i whenever the lock state permits i.
- Arbitration in NONE (combinational, per cycle, at most one gnt high):
  - Only one req high: that requester is granted.
  - Both high: the requester selected by the pointer is granted.
  - On every transfer by i, the pointer moves to the other requester. Under contention, strict alternation results.
- Lock transitions, evaluated at a transfer edge by i:
  - lock_i=1 → OWNi.
  - lock_i=0 → NONE.
  - If req_i is low while in OWNi, the state stays OWNi. No timeout; the owner must release with a lock_i=0 transfer.
- Issue timing: transfer at edge ending cycle T means that in cycle T+1, cache_addr=addr_i, cache_dataIn=wdata_i, cache_WE=we_i.
  - Cycles with no transfer: cache_WE=0; cache_addr and cache_dataIn hold their previous values.
- Write completion: writes complete at the edge ending cycle T+1. No response is generated.
- Read return: a read transferred at the end of T asserts rvalid_i for exactly one cycle, in cycle T+1+RD_LAT, with rdata=cache_dataOut.
  - Tracking uses a shift pipeline of depth RD_LAT+1 carrying {valid, id}. Full throughput: one read per cycle, reads may be outstanding from both requesters, and they return in issue order.
- Read-after-write: a read of an address written by the immediately preceding transfer returns the new data. Cache write order is preserved because issue is strictly serial.
- Address handling: no address decode or aliasing in this block. The full AW bits are passed through (0x8000 is distinct from 0x0000).
- Simultaneous events: a new transfer may occur in the same cycle an rvalid is returned. Both rvalids are never high together.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; after release with r0_req=r1_req=0, cache_WE stays 0 and gnts are 0.
- Single requester: r0 writes 0x0000=AAAA, 0x0001=BBBB, 0x8000=CCCC back-to-back, then reads all three back-to-back → cache_WE high for 3 cycles; r0_rvalid high in the 3 cycles starting 2 cycles after the first read transfer (RD_LAT=1); rdata=AAAA, BBBB, CCCC.
- Contention: r0 and r1 both hold req for 4 cycles after reset → grant order 0,1,0,1; each requester's rvalids return only to that requester, in order.
- Lock: r1 issues read 0x0010 with lock=1 while r0_req=1, then write 0x0010 with lock=0 → r0_gnt stays 0 through both r1 transfers; r0 is granted the cycle after the unlock transfer.
- Reset mid-lock: r0 in OWN0 with one read outstanding, pulse rst → no rvalid appears for that read; lock=NONE; r1 is granted on the first cycle with rst low.
- RD_LAT=3 variant: read 0x0001 after writing BBBB → r0_rvalid appears exactly 4 cycles after the read transfer edge with rdata=BBBB.
